// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, special opcodes, the ID/EX payload struct and
// the operand-usage helpers used by hazard and forwarding logic.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int OPC_W  = 5;

  localparam logic [OPC_W-1:0] OPC_MOV = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_NOT = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_POP = 5'b10000;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic              is_load;
  } id_ex_t;

  function automatic logic uses_a(input logic [OPC_W-1:0] opcode);
    return opcode != OPC_MOV;
  endfunction

  function automatic logic uses_b(input logic [OPC_W-1:0] opcode, input logic use_imm);
    return !use_imm && (opcode != OPC_NOT);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand source select (EX / MEM / WB / register file) plus hazard flag.
// Build option ID_EX_FORWARDING_EN enables bypassing; otherwise any match stalls.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  input  logic              mem_rd_we,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic              wb_rd_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // r0 is hardwired, so it never depends on an in-flight producer
  assign live    = used && (src != '0);
  assign ex_hit  = live && ex_valid  && ex_rd_we  && (ex_rd  == src);
  assign mem_hit = live && mem_valid && mem_rd_we && (mem_rd == src);
  assign wb_hit  = live && wb_valid  && wb_rd_we  && (wb_rd  == src);

`ifdef ID_EX_FORWARDING_EN
  always_comb begin
    data = rf_data;
    if (ex_hit && !ex_is_load)
      data = ex_data;
    else if (mem_hit && !mem_is_load)
      data = mem_data;
    else if (wb_hit)
      data = wb_data;
  end

  assign hazard = (ex_hit && ex_is_load) || (mem_hit && mem_is_load);
`else
  logic unused_fwd;

  assign data       = rf_data;
  assign hazard     = ex_hit || mem_hit || wb_hit;
  assign unused_fwd = ^{ex_is_load, mem_is_load, ex_data, mem_data, wb_data};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, load-use stalls,
// flush and bubble counting. Forwarding is enabled by ID_EX_FORWARDING_EN.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_AW-1:0] in_rs_a,
  input  logic [REG_AW-1:0] in_rs_b,
  input  logic [DATA_W-1:0] in_data_a,
  input  logic [DATA_W-1:0] in_data_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              mem_valid,
  input  logic              mem_rd_we,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_valid,
  input  logic              wb_rd_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_A_in,
  output logic [DATA_W-1:0] ALU_B_in,
  output logic [OPC_W-1:0]  opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [15:0]       bubble_cnt
);

  id_ex_t            held_reg;
  id_ex_t            held_next;
  logic              valid_reg;
  logic [15:0]       bubble_reg;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              use_a;
  logic              use_b;
  logic              haz_a;
  logic              haz_b;
  logic              hazard;
  logic              capture;

  assign use_a = uses_a(in_opcode);
  assign use_b = uses_b(in_opcode, in_use_imm);

  fwd_mux u_fwd_a (
    .src(in_rs_a), .used(use_a), .rf_data(in_data_a),
    .ex_valid(valid_reg), .ex_rd_we(held_reg.rd_we), .ex_is_load(held_reg.is_load),
    .ex_rd(held_reg.rd), .ex_data(alu_result),
    .mem_valid(mem_valid), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_a), .hazard(haz_a)
  );

  fwd_mux u_fwd_b (
    .src(in_rs_b), .used(use_b), .rf_data(in_data_b),
    .ex_valid(valid_reg), .ex_rd_we(held_reg.rd_we), .ex_is_load(held_reg.is_load),
    .ex_rd(held_reg.rd), .ex_data(alu_result),
    .mem_valid(mem_valid), .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_rd_we(wb_rd_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(fwd_b), .hazard(haz_b)
  );

  assign hazard   = haz_a || haz_b;
  assign in_ready = !flush && !hazard && (!valid_reg || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    held_next         = held_reg;
    held_next.opcode  = in_opcode;
    held_next.a       = fwd_a;
    held_next.b       = in_use_imm ? in_imm : fwd_b;
    held_next.rd      = in_rd;
    held_next.rd_we   = in_rd_we;
    held_next.is_load = in_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg   <= '0;
      valid_reg  <= 1'b0;
      bubble_reg <= '0;
    end else begin
      if (flush)
        valid_reg <= 1'b0;
      else if (capture) begin
        held_reg  <= held_next;
        valid_reg <= 1'b1;
      end else if (out_ready)
        valid_reg <= 1'b0;

      if (in_valid && hazard && !flush && (bubble_reg != 16'hFFFF))
        bubble_reg <= bubble_reg + 16'd1;
    end
  end

  assign out_valid   = valid_reg;
  assign ALU_A_in    = held_reg.a;
  assign ALU_B_in    = held_reg.b;
  assign opcode      = held_reg.opcode;
  assign out_rd      = held_reg.rd;
  assign out_rd_we   = held_reg.rd_we;
  assign out_is_load = held_reg.is_load;
  assign bubble_cnt  = bubble_reg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register that directly feeds the ALU. It accepts a decoded instruction over a valid/ready handshake and selects each operand from one of four sources: the register file, the instruction this stage is currently presenting to the ALU, the MEM stage, or the WB stage. It inserts bubbles on load-use hazards, supports flush, and presents registered `ALU_A_in`, `ALU_B_in` and `opcode` to the ALU.

## Interface
- `DATA_W`, 32, operand/result width
- `REG_AW`, 4, register index width; register 0 is never a hazard or forwarding target
- `OPC_W`, 5, opcode width
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: discard held and incoming instruction
- `in_valid` in 1 / `in_ready` out 1: decode handshake
- `in_opcode` in OPC_W; `in_rs_a`, `in_rs_b` in REG_AW; `in_data_a`, `in_data_b` in DATA_W (register-file reads)
- `in_imm` in DATA_W; `in_use_imm` in 1: B operand is `in_imm`
- `in_rd` in REG_AW; `in_rd_we` in 1; `in_is_load` in 1
- `alu_result` in DATA_W: ALU output for the instruction held here
- `mem_valid`, `mem_rd_we`, `mem_is_load` in 1; `mem_rd` in REG_AW; `mem_data` in DATA_W
- `wb_valid`, `wb_rd_we` in 1; `wb_rd` in REG_AW; `wb_data` in DATA_W
- `out_valid` out 1 / `out_ready` in 1: execute handshake
- `ALU_A_in`, `ALU_B_in` out DATA_W; `opcode` out OPC_W; `out_rd` out REG_AW; `out_rd_we`, `out_is_load` out 1
- `bubble_cnt` out 16: saturating count of hazard-stall cycles

## Operation
- Source usage: A is used unless the opcode is MOV (5'b01100). B is used unless `in_use_imm` is set or the opcode is NOT (5'b01001).
- Producer match: a producer stage matches a used source when it is valid, has `rd_we` set, has `rd` equal to the source index, and that index is nonzero.
- Forwarding priority, highest first:
  - This stage (`out_valid`, not `out_is_load`) supplies `alu_result`.
  - MEM (not `mem_is_load`) supplies `mem_data`.
  - WB supplies `wb_data`.
  - Otherwise the register-file data is used.
- Load-use hazard: either of the following matches a used source.
  - This stage holds a load (`out_valid && out_is_load`).
  - MEM holds a load (`mem_valid && mem_is_load`).
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Capture on `in_valid && in_ready`: the forwarded operands, opcode, `rd`, `rd_we` and `is_load` are registered, and `out_valid` is set to 1.
- `out_ready && out_valid` with no capture clears `out_valid`. This produces a bubble.
- Forwarding and hazard detection are evaluated once, at capture. Held operands do not change while `out_ready` is low.
- `bubble_cnt` increments in each cycle where `in_valid && hazard && !flush`, and saturates at 16'hFFFF.

## Timing
- Reset (async, `rst_n` low):
  - `out_valid`, `ALU_A_in`, `ALU_B_in`, `opcode`, `out_rd`, `out_rd_we`, `out_is_load` and `bubble_cnt` all go to 0.
  - `in_ready` comes up 1 after release.
- Latency: 1 cycle from capture to outputs. Full throughput of one instruction per cycle when there is no hazard.
- Flush: the next state is `out_valid` = 0. The incoming instruction is dropped. Flush has priority over capture, and `bubble_cnt` does not count the flush cycle.
- Simultaneous `out_ready` and capture: the old instruction leaves, and the new one loads in the same edge.
- Load-use: a dependent instruction that directly follows a load sees 2 bubble cycles, one while the load is in this stage and one while it is in MEM. It then captures with `wb_data`.
- Reset mid-hold: the held instruction is lost. No handshake state survives reset.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding and priority behave as in Operation.
- `ID_EX_FORWARDING_EN` undefined: no forwarding. Any match against this stage, MEM or WB is a hazard and stalls until the register file holds the value. Operands always come from `in_data_*` or `in_imm`.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode constants `OPC_MOV`, `OPC_NOT` and `OPC_POP`;
  - the width constants;
  - a struct `id_ex_t` with fields opcode, a, b, rd, rd_we, is_load;
  - functions `uses_a(opcode)` and `uses_b(opcode, use_imm)`.
- Sub-module `fwd_mux`: one combinational instance per operand. It returns the selected data and a hazard bit.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-stream, then release.
  - Required response: all outputs are 0 and `in_ready`=1 on the first cycle after release.
- Back-to-back EX forward:
  - Stimulus: ADD r1 (result 5), then SUB r2=r1-r3 with `in_data_a`=99.
  - Required response: second `ALU_A_in`=5, no bubble.
- Priority:
  - Stimulus: r4 is written by MEM (7) and WB (9), and is read with `in_data_a`=1.
  - Required response: `ALU_A_in`=7. With MEM invalid, 9.
- Load-use:
  - Stimulus: POP r5, then AND r6=r5&imm.
  - Required response: 2 cycles with `in_ready`=0, `bubble_cnt`=2, then capture with `wb_data`.
- Backpressure plus flush:
  - Stimulus: hold `out_ready`=0 for 3 cycles.
  - Required response: outputs remain stable and `in_ready`=0.
  - Stimulus: assert `flush`.
  - Required response: `out_valid`=0 next cycle, and the incoming instruction is dropped.
- Macro off:
  - Stimulus: the back-to-back case from the forwarding scenario.
  - Required response: stalls until the producer leaves WB, then `ALU_A_in` equals the updated `in_data_a`.
